// File: rtl/sipo_frame_pkg.sv
// -----------------------------------------------------------------------------
// sipo_frame_pkg
// Shared definitions for the framed serial-to-parallel receiver:
//   state_t    - controller state encoding (2 bits)
//   cnt_width  - width of the data-bit counter for a given word width
// -----------------------------------------------------------------------------
package sipo_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // One extra bit so the counter can hold WIDTH itself without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// -----------------------------------------------------------------------------
// sipo_shift_reg
// Serial-in / parallel-out shift register.
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-low reset (clears q)
//   shift_en  - shift din in this cycle
//   din       - serial data in
//   q         - parallel contents [WIDTH-1:0]
// Parameters:
//   WIDTH     - register width (2..32)
//   LSB_FIRST - 1: shift right, new bit enters at MSB (first bit ends in q[0])
//               0: shift left, new bit enters at bit 0 (first bit ends in MSB)
// -----------------------------------------------------------------------------
module sipo_shift_reg #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    q <= '0;
                else if (shift_en)
                    q <= {din, q[WIDTH-1:1]};
            end
        end else begin : g_msb_first
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    q <= '0;
                else if (shift_en)
                    q <= {q[WIDTH-2:0], din};
            end
        end
    endgenerate

endmodule

// File: rtl/sipo_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sipo_frame_ctrl
// Sequences a framed serial receive (start 0, WIDTH data bits, optional even
// parity bit, stop 1) into a parallel word handed off over valid/ready.
// Optional feature macro: SIPO_FRAME_CTRL_PARITY_CHECK_EN (adds PARITY state
// and even-parity check; frame becomes WIDTH+3 strobes instead of WIDTH+2).
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   din        - serial data, sampled only when bit_en=1
//   bit_en     - one-cycle bit strobe
//   dout       - assembled word, stable while dout_valid=1
//   dout_valid - word available
//   dout_ready - consumer takes the word when dout_valid && dout_ready
//   busy       - controller is not IDLE
//   frame_err  - one-cycle pulse: bad stop bit (or bad parity)
//   overrun    - one-cycle pulse: good frame dropped, holding register full
// -----------------------------------------------------------------------------
module sipo_frame_ctrl
    import sipo_frame_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             bit_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_d;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q;
    logic             shift_en;
    logic             frame_ok;
    logic             load;
    logic             err_d;
    logic             ovr_d;

    assign shift_en = bit_en && (state == DATA);
    assign busy     = (state != IDLE);

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .din      (din),
        .q        (q)
    );

`ifdef SIPO_FRAME_CTRL_PARITY_CHECK_EN
    logic par_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            par_bit <= 1'b0;
        else if (bit_en && state == PARITY)
            par_bit <= din;
    end

    // Even parity: data bits XOR parity bit must be zero.
    assign frame_ok = din && !((^q) ^ par_bit);
`else
    assign frame_ok = din;
`endif

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state;
        load    = 1'b0;
        err_d   = 1'b0;
        ovr_d   = 1'b0;
        case (state)
            IDLE: begin
                if (bit_en && !din)
                    state_d = DATA;
            end
            DATA: begin
                if (bit_en && cnt == CW'(WIDTH - 1))
`ifdef SIPO_FRAME_CTRL_PARITY_CHECK_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
            end
`ifdef SIPO_FRAME_CTRL_PARITY_CHECK_EN
            PARITY: begin
                if (bit_en)
                    state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_en) begin
                    state_d = IDLE;
                    if (frame_ok) begin
                        // The holding register is free if empty or being
                        // drained in this very cycle.
                        if (!dout_valid || dout_ready)
                            load = 1'b1;
                        else
                            ovr_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Counter restarts only on the start bit; it holds outside DATA.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (state == IDLE && bit_en && !din)
            cnt <= '0;
        else if (shift_en)
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= err_d;
            overrun   <= ovr_d;
            if (load) begin
                dout       <= q;
                dout_valid <= 1'b1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sipo_frame_ctrl
// Directed bench for sipo_frame_ctrl. Two instances share all inputs: one
// with LSB_FIRST=1 and one with LSB_FIRST=0. Words are described in arrival
// order: bit i of a stimulus word is the i-th data bit on the wire.
// -----------------------------------------------------------------------------
module tb_sipo_frame_ctrl;

    logic       clk;
    logic       rst;
    logic       din;
    logic       bit_en;
    logic       dout_ready;
    logic [7:0] dout_l;
    logic       valid_l;
    logic       busy_l;
    logic       err_l;
    logic       ovr_l;
    logic [7:0] dout_m;
    logic       valid_m;
    logic       busy_m;
    logic       err_m;
    logic       ovr_m;

    int checks = 0;
    int errors = 0;

`ifdef SIPO_FRAME_CTRL_PARITY_CHECK_EN
    logic par_flip = 1'b0;
`endif

    sipo_frame_ctrl #(.WIDTH(8), .LSB_FIRST(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .bit_en     (bit_en),
        .dout       (dout_l),
        .dout_valid (valid_l),
        .dout_ready (dout_ready),
        .busy       (busy_l),
        .frame_err  (err_l),
        .overrun    (ovr_l)
    );

    sipo_frame_ctrl #(.WIDTH(8), .LSB_FIRST(0)) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .bit_en     (bit_en),
        .dout       (dout_m),
        .dout_valid (valid_m),
        .dout_ready (dout_ready),
        .busy       (busy_m),
        .frame_err  (err_m),
        .overrun    (ovr_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] word;
        logic       stop;
        logic       exp_valid;
        logic       exp_err;
        logic [7:0] exp_lsb;
        logic [7:0] exp_msb;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobe; returns 1 time unit after the consuming edge.
    task automatic send_bit(input logic b);
        @(negedge clk);
        din    = b;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        din    = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] w, input logic stop, input logic ready_at_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++)
            send_bit(w[i]);
`ifdef SIPO_FRAME_CTRL_PARITY_CHECK_EN
        send_bit((^w) ^ par_flip);
`endif
        @(negedge clk);
        din    = stop;
        bit_en = 1'b1;
        if (ready_at_stop)
            dout_ready = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        din    = 1'b1;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 8'hA5};
        vecs[1] = '{8'h03, 1'b1, 1'b1, 1'b0, 8'h03, 8'hC0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
        vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01, 8'h80};
        vecs[4] = '{8'hF0, 1'b1, 1'b1, 1'b0, 8'hF0, 8'h0F};
        vecs[5] = '{8'h2C, 1'b1, 1'b1, 1'b0, 8'h2C, 8'h34};
        vecs[6] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
        vecs[7] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};

        rst        = 1'b0;
        din        = 1'b1;
        bit_en     = 1'b0;
        dout_ready = 1'b1;
        #3;
        check("reset dout",       32'(dout_l),  32'h0);
        check("reset dout_valid", 32'(valid_l), 32'h0);
        check("reset busy",       32'(busy_l),  32'h0);
        check("reset frame_err",  32'(err_l),   32'h0);
        check("reset overrun",    32'(ovr_l),   32'h0);
        check("reset dout msb",   32'(dout_m),  32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Idle line strobes must not start a frame.
        send_bit(1'b1);
        check("idle one busy",  32'(busy_l),  32'h0);
        check("idle one valid", 32'(valid_l), 32'h0);

        // Table: one frame per vector with dout_ready held high.
        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].word, vecs[v].stop, 1'b0);
            check($sformatf("v%0d valid", v), 32'(valid_l), 32'(vecs[v].exp_valid));
            check($sformatf("v%0d frame_err", v), 32'(err_l), 32'(vecs[v].exp_err));
            check($sformatf("v%0d overrun", v), 32'(ovr_l), 32'h0);
            check($sformatf("v%0d busy", v), 32'(busy_l), 32'h0);
            if (vecs[v].exp_valid) begin
                check($sformatf("v%0d dout lsb", v), 32'(dout_l), 32'(vecs[v].exp_lsb));
                check($sformatf("v%0d dout msb", v), 32'(dout_m), 32'(vecs[v].exp_msb));
            end
            tick();
            check($sformatf("v%0d valid drop", v), 32'(valid_l), 32'h0);
            check($sformatf("v%0d err pulse end", v), 32'(err_l), 32'h0);
        end

        // Overrun: holding register full when the second stop bit arrives.
        dout_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        check("ovr first valid", 32'(valid_l), 32'h1);
        check("ovr first dout",  32'(dout_l),  32'h11);
        send_frame(8'h22, 1'b1, 1'b0);
        check("ovr pulse",      32'(ovr_l),   32'h1);
        check("ovr no err",     32'(err_l),   32'h0);
        check("ovr dout held",  32'(dout_l),  32'h11);
        check("ovr valid held", 32'(valid_l), 32'h1);
        tick();
        check("ovr pulse end",  32'(ovr_l),   32'h0);
        check("ovr still held", 32'(dout_l),  32'h11);
        // Ready rises in the stop-strobe cycle: new word replaces the old one.
        send_frame(8'h22, 1'b1, 1'b1);
        check("swap dout",    32'(dout_l),  32'h22);
        check("swap valid",   32'(valid_l), 32'h1);
        check("swap no ovr",  32'(ovr_l),   32'h0);
        tick();
        check("swap drained", 32'(valid_l), 32'h0);

        // Asynchronous reset mid-frame with a word held.
        dout_ready = 1'b0;
        send_frame(8'h77, 1'b1, 1'b0);
        check("held before rst", 32'(valid_l), 32'h1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++)
            send_bit(1'b1);
        check("mid frame busy", 32'(busy_l), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("async rst dout",  32'(dout_l),  32'h0);
        check("async rst valid", 32'(valid_l), 32'h0);
        check("async rst busy",  32'(busy_l),  32'h0);
        check("async rst err",   32'(err_l),   32'h0);
        check("async rst ovr",   32'(ovr_l),   32'h0);
        @(negedge clk);
        rst        = 1'b1;
        dout_ready = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b0);
        check("post rst valid", 32'(valid_l), 32'h1);
        check("post rst dout",  32'(dout_l),  32'h5A);
        check("post rst msb",   32'(dout_m),  32'h5A);
        tick();

`ifdef SIPO_FRAME_CTRL_PARITY_CHECK_EN
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0);
        check("par good valid", 32'(valid_l), 32'h1);
        check("par good dout",  32'(dout_l),  32'h07);
        check("par good err",   32'(err_l),   32'h0);
        tick();
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0);
        check("par bad err",   32'(err_l),   32'h1);
        check("par bad valid", 32'(valid_l), 32'h0);
        par_flip = 1'b0;
        tick();
        check("par bad err end", 32'(err_l), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
